dmem_bridge: RTL and testbench

Data-memory bridge directly downstream of the memory stage. It registers the stage's combinational load/store request (`r_v`, `w_v`, `req_adr`, `req_data`, `req_strobe`) and drives a valid/ready data-bus transaction. It returns `hit`, `mem_res` and `mem_res_error` to the memory stage, and holds the stage with `busy` until the access completes.

---
 rtl/cpu_parameters.sv | 39 +++
 rtl/dmem_watchdog.sv | 31 +++
 rtl/dmem_bridge.sv | 157 +++++++++++++++
 tb/tb_dmem_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_parameters.sv
// Shared CPU-side definitions for the data-memory bridge: datapath width,
// bridge FSM states and the request legality helper.
package cpu_parameters;

    localparam int unsigned xlen = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } dmem_state_t;

    // A request is legal when its lane mask is a naturally aligned byte,
    // halfword or word, and it is not simultaneously a load and a store.
    function automatic logic req_legal(
        input logic       rd,
        input logic       wr,
        input logic [3:0] strobe,
        input logic [1:0] off
    );
        logic       shape_ok;
        logic [1:0] low;
        shape_ok = 1'b1;
        low      = 2'd0;
        case (strobe)
            4'b0001: low = 2'd0;
            4'b0010: low = 2'd1;
            4'b0100: low = 2'd2;
            4'b1000: low = 2'd3;
            4'b0011: low = 2'd0;
            4'b1100: low = 2'd2;
            4'b1111: low = 2'd0;
            default: shape_ok = 1'b0;
        endcase
        return shape_ok && (low == off) && !(rd && wr);
    endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Bus watchdog for dmem_bridge: counts cycles spent on an outstanding bus
// access and flags expiry on the cycle the count reaches TIMEOUT.
module dmem_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_inc;

    assign w_inc     = r_cnt + 1'b1;
    assign o_expired = i_en && (w_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_inc;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage to valid/ready data-bus bridge with lane alignment and fault
// reporting. Define DMEM_TIMEOUT_EN to enable the bus watchdog (dmem_watchdog).
module dmem_bridge
    import cpu_parameters::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_v,
    input  logic            w_v,
    input  logic [xlen-1:0] req_adr,
    input  logic [xlen-1:0] req_data,
    input  logic [3:0]      req_strobe,
    output logic            busy,
    output logic            hit,
    output logic [xlen-1:0] mem_res,
    output logic            mem_res_error,
    output logic            bus_req_v,
    output logic            bus_req_we,
    output logic [xlen-1:0] bus_req_adr,
    output logic [xlen-1:0] bus_req_data,
    output logic [3:0]      bus_req_strobe,
    input  logic            bus_req_ready,
    input  logic            bus_rsp_v,
    input  logic [xlen-1:0] bus_rsp_data,
    input  logic            bus_rsp_err
);

    dmem_state_t     r_state;
    dmem_state_t     w_next;
    logic [xlen-1:0] r_adr;
    logic [1:0]      r_off;
    logic [xlen-1:0] r_wdata;
    logic [3:0]      r_strobe;
    logic            r_we;
    logic [xlen-1:0] r_res;
    logic            r_err;
    logic            w_req;
    logic            w_legal;
    logic            w_expired;
    logic            w_wd_clr;
    logic            w_wd_en;

    assign w_req    = r_v | w_v;
    assign w_legal  = req_legal(r_v, w_v, req_strobe, req_adr[1:0]);
    assign w_wd_clr = (r_state == IDLE) && w_req && w_legal;
    assign w_wd_en  = (r_state == REQ) || (r_state == WAIT);

`ifdef DMEM_TIMEOUT_EN
    dmem_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        hit       = 1'b0;
        bus_req_v = 1'b0;
        case (r_state)
            IDLE: begin
                busy = w_req;
                if (w_req) begin
                    w_next = w_legal ? REQ : DONE;
                end
            end
            REQ: begin
                busy      = 1'b1;
                bus_req_v = 1'b1;
                if (w_expired) begin
                    w_next = DONE;
                end else if (bus_req_ready) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (w_expired || bus_rsp_v) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                hit    = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Write data is lane-placed at capture so the bus fields are plain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adr    <= '0;
            r_off    <= '0;
            r_wdata  <= '0;
            r_strobe <= '0;
            r_we     <= 1'b0;
            r_res    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_adr    <= {req_adr[xlen-1:2], 2'b00};
                        r_off    <= req_adr[1:0];
                        r_wdata  <= req_data << {req_adr[1:0], 3'b000};
                        r_strobe <= req_strobe;
                        r_we     <= w_v;
                        r_res    <= '0;
                        r_err    <= !w_legal;
                    end
                end
                REQ: begin
                    if (w_expired) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (w_expired) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end else if (bus_rsp_v) begin
                        r_res <= r_we ? '0 : (bus_rsp_data >> {r_off, 3'b000});
                        r_err <= bus_rsp_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_res        = r_res;
    assign mem_res_error  = r_err;
    assign bus_req_we     = r_we;
    assign bus_req_adr    = r_adr;
    assign bus_req_data   = r_wdata;
    assign bus_req_strobe = r_strobe;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed transactions, a bus responder
// and a transaction-level model checked every cycle.
module tb_dmem_bridge;

    localparam int unsigned TB_TO = 8;

    logic        clk;
    logic        rst_n;
    logic        r_v;
    logic        w_v;
    logic [31:0] req_adr;
    logic [31:0] req_data;
    logic [3:0]  req_strobe;
    logic        busy;
    logic        hit;
    logic [31:0] mem_res;
    logic        mem_res_error;
    logic        bus_req_v;
    logic        bus_req_we;
    logic [31:0] bus_req_adr;
    logic [31:0] bus_req_data;
    logic [3:0]  bus_req_strobe;
    logic        bus_req_ready;
    logic        bus_rsp_v;
    logic [31:0] bus_rsp_data;
    logic        bus_rsp_err;

    dmem_bridge #(
        .TIMEOUT(TB_TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .r_v            (r_v),
        .w_v            (w_v),
        .req_adr        (req_adr),
        .req_data       (req_data),
        .req_strobe     (req_strobe),
        .busy           (busy),
        .hit            (hit),
        .mem_res        (mem_res),
        .mem_res_error  (mem_res_error),
        .bus_req_v      (bus_req_v),
        .bus_req_we     (bus_req_we),
        .bus_req_adr    (bus_req_adr),
        .bus_req_data   (bus_req_data),
        .bus_req_strobe (bus_req_strobe),
        .bus_req_ready  (bus_req_ready),
        .bus_rsp_v      (bus_rsp_v),
        .bus_rsp_data   (bus_rsp_data),
        .bus_rsp_err    (bus_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // responder configuration
    int          cfg_rdy_wait = 0;
    int          cfg_rsp_wait = 0;
    bit          cfg_respond  = 1'b0;
    logic [31:0] cfg_rsp_data = '0;
    logic        cfg_rsp_err  = 1'b0;
    int          stray_req    = 0;

    // model expectations for the current transaction
    int          txn_id = 0;
    int          done_id = 0;
    int          abort_id = 0;
    bit          m_legal;
    int          m_hit;
    int          m_req_last;
    logic [31:0] m_adr;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic        m_we;
    logic [31:0] m_res;
    logic        m_err;

    // observations for the literal pins
    logic [31:0] last_res;
    logic        last_err;
    int          last_hit_cyc;
    logic [31:0] seen_adr;
    logic [31:0] seen_data;
    logic [3:0]  seen_strb;
    bit          seen_req;

    function automatic bit model_legal(input logic rd, wr, input logic [31:0] adr, input logic [3:0] s);
        int lowest;
        lowest = -1;
        for (int i = 3; i >= 0; i--) if (s[i]) lowest = i;
        return !(rd && wr) && (s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})
               && (lowest == int'(adr[1:0]));
    endfunction

    task automatic model_txn(input logic rd, wr, input logic [31:0] adr, data, input logic [3:0] s,
                             input int rdy_w, rsp_w, input bit respond, input logic [31:0] rdata,
                             input logic rerr);
        int  n;
        bit  to_en;
`ifdef DMEM_TIMEOUT_EN
        to_en = 1'b1;
`else
        to_en = 1'b0;
`endif
        m_legal = model_legal(rd, wr, adr, s);
        m_adr   = adr & 32'hFFFF_FFFC;
        m_data  = data << (8 * adr[1:0]);
        m_strb  = s;
        m_we    = wr;
        n = respond ? (rdy_w + rsp_w + 2) : 32'h3FFF_FFFF;
        if (!m_legal) begin
            m_hit = 1; m_req_last = 0; m_res = '0; m_err = 1'b1;
        end else if (to_en && n > int'(TB_TO)) begin
            m_hit = 1 + int'(TB_TO);
            m_req_last = (1 + rdy_w < int'(TB_TO)) ? 1 + rdy_w : int'(TB_TO);
            m_res = '0; m_err = 1'b1;
        end else begin
            m_hit = 1 + n; m_req_last = 1 + rdy_w;
            m_res = wr ? 32'h0 : (rdata >> (8 * adr[1:0]));
            m_err = rerr;
        end
    endtask

    // bus responder
    initial begin
        int req_cnt;
        int rsp_cnt;
        int stray_seen;
        bit pend;
        bit hs;
        req_cnt = 0; rsp_cnt = 0; stray_seen = 0; pend = 0;
        bus_req_ready = 1'b0; bus_rsp_v = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            hs = bus_req_v && bus_req_ready;
            @(posedge clk);
            #1;
            bus_rsp_v = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
            if (hs && cfg_respond) begin pend = 1; rsp_cnt = cfg_rsp_wait; end
            if (pend) begin
                if (rsp_cnt == 0) begin
                    bus_rsp_v = 1'b1; bus_rsp_data = cfg_rsp_data; bus_rsp_err = cfg_rsp_err; pend = 0;
                end else rsp_cnt--;
            end
            if (stray_req != stray_seen) begin
                stray_seen = stray_req; bus_rsp_v = 1'b1; bus_rsp_data = 32'h7777_7777; bus_rsp_err = 1'b1;
            end
            if (bus_req_v) begin
                bus_req_ready = (req_cnt >= cfg_rdy_wait); req_cnt++;
            end else begin
                bus_req_ready = 1'b0; req_cnt = 0;
            end
        end
    end

    // compare process
    initial begin
        int cyc;
        int cur;
        bit act;
        cyc = 0; cur = 0; act = 0;
        forever begin
            @(negedge clk);
            if (!act && txn_id != cur) begin act = 1; cur = txn_id; cyc = 0; seen_req = 0; end
            if (act && abort_id == cur) begin act = 0; done_id = cur; end
            if (act) begin
                chk("hit", hit, 32'(cyc == m_hit));
                chk("busy", busy, 32'(cyc != m_hit));
                chk("bus_req_v", bus_req_v, 32'(m_legal && cyc >= 1 && cyc <= m_req_last));
                if (bus_req_v) begin
                    chk("bus_req_adr", bus_req_adr, m_adr);
                    chk("bus_req_data", bus_req_data, m_data);
                    chk("bus_req_strobe", bus_req_strobe, m_strb);
                    chk("bus_req_we", bus_req_we, m_we);
                    seen_req = 1; seen_adr = bus_req_adr; seen_data = bus_req_data; seen_strb = bus_req_strobe;
                end
                if (cyc == m_hit || hit) begin
                    chk("mem_res", mem_res, m_res);
                    chk("mem_res_error", mem_res_error, m_err);
                    last_res = mem_res; last_err = mem_res_error; last_hit_cyc = cyc;
                    act = 0; done_id = cur;
                end
                cyc++;
            end else begin
                chk("idle_hit", hit, 0);
                chk("idle_bus_req_v", bus_req_v, 0);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hit"}, hit, 0);
        chk({tag, "_err"}, mem_res_error, 0);
        chk({tag, "_req_v"}, bus_req_v, 0);
        chk({tag, "_we"}, bus_req_we, 0);
        chk({tag, "_res"}, mem_res, 0);
        chk({tag, "_adr"}, bus_req_adr, 0);
        chk({tag, "_data"}, bus_req_data, 0);
        chk({tag, "_strb"}, bus_req_strobe, 0);
    endtask

    task automatic run_txn(input logic rd, wr, input logic [31:0] adr, data, input logic [3:0] s,
                           input int rdy_w, rsp_w, input bit respond, input logic [31:0] rdata,
                           input logic rerr, input int abort_at);
        int budget;
        @(posedge clk);
        #1;
        cfg_rdy_wait = rdy_w; cfg_rsp_wait = rsp_w; cfg_respond = respond;
        cfg_rsp_data = rdata; cfg_rsp_err = rerr;
        model_txn(rd, wr, adr, data, s, rdy_w, rsp_w, respond, rdata, rerr);
        r_v = rd; w_v = wr; req_adr = adr; req_data = data; req_strobe = s;
        last_hit_cyc = -1; seen_req = 0;
        txn_id++;
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #1;
            r_v = 1'b0; w_v = 1'b0;
            abort_id = txn_id;
            rst_n = 1'b0;
            #1;
            check_reset_values("midrst");
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
        end
        budget = 0;
        while (done_id != txn_id && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        if (done_id != txn_id) chk("txn_budget", 32'(budget), 0);
        #1;
        r_v = 1'b0; w_v = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; r_v = 1'b0; w_v = 1'b0;
        req_adr = '0; req_data = '0; req_strobe = '0;
        #2;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // word load, immediate ready and response
        run_txn(1, 0, 32'h100, 32'h0, 4'b1111, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        chk("lit_word_adr", seen_adr, 32'h100);
        chk("lit_word_res", last_res, 32'hDEADBEEF);
        chk("lit_word_lat", 32'(last_hit_cyc), 3);

        // byte load on top lane
        run_txn(1, 0, 32'h103, 32'h0, 4'b1000, 0, 0, 1, 32'h11223344, 0, 0);
        chk("lit_byte_res", last_res, 32'h0000_0011);
        chk("lit_byte_strb", 32'(seen_strb), 32'h8);

        // halfword store, ready held off 4 cycles; response data ignored
        run_txn(0, 1, 32'h202, 32'h0000ABCD, 4'b1100, 4, 0, 1, 32'hFFFFFFFF, 0, 0);
        chk("lit_hst_data", seen_data, 32'hABCD_0000);
        chk("lit_hst_adr", seen_adr, 32'h200);
        chk("lit_hst_res", last_res, 32'h0);
        chk("lit_hst_lat", 32'(last_hit_cyc), 7);

        // misaligned halfword: no bus traffic, error hit at cycle 1
        run_txn(1, 0, 32'h101, 32'h0, 4'b0110, 0, 0, 1, 32'h0, 0, 0);
        chk("lit_mis_err", last_err, 1);
        chk("lit_mis_lat", 32'(last_hit_cyc), 1);
        chk("lit_mis_noreq", 32'(seen_req), 0);

        // bus fault on a load with response delay
        run_txn(1, 0, 32'h104, 32'h0, 4'b0011, 2, 2, 1, 32'h12345678, 1, 0);
        chk("lit_berr_err", last_err, 1);

        // simultaneous load and store, empty strobe, bad offset: all illegal
        run_txn(1, 1, 32'h108, 32'h1, 4'b1111, 0, 0, 1, 32'h0, 0, 0);
        run_txn(0, 1, 32'h108, 32'h1, 4'b0000, 0, 0, 1, 32'h0, 0, 0);
        run_txn(1, 0, 32'h10A, 32'h0, 4'b0001, 0, 0, 1, 32'h0, 0, 0);

        // byte store lane 1, halfword load upper
        run_txn(0, 1, 32'h301, 32'h0000005A, 4'b0010, 1, 1, 1, 32'h0, 0, 0);
        chk("lit_bst_data", seen_data, 32'h0000_5A00);
        run_txn(1, 0, 32'h302, 32'h0, 4'b1100, 0, 3, 1, 32'hCAFEF00D, 0, 0);
        chk("lit_hld_res", last_res, 32'h0000_CAFE);

        // response outside WAIT is dropped
        @(posedge clk); #1; stray_req++;
        repeat (4) @(posedge clk);

`ifdef DMEM_TIMEOUT_EN
        run_txn(1, 0, 32'h400, 32'h0, 4'b1111, 0, 0, 0, 32'h0, 0, 0);
        chk("lit_to_lat", 32'(last_hit_cyc), 9);
        chk("lit_to_err", last_err, 1);
        run_txn(1, 0, 32'h404, 32'h0, 4'b1111, 1000, 0, 0, 32'h0, 0, 0);
        run_txn(1, 0, 32'h408, 32'h0, 4'b1111, 0, 10, 1, 32'h55555555, 0, 0);
        chk("lit_late_res", last_res, 32'h0);
        repeat (8) @(posedge clk);
`else
        run_txn(1, 0, 32'h400, 32'h0, 4'b1111, 0, 20, 1, 32'h55AA55AA, 0, 0);
        chk("lit_long_lat", 32'(last_hit_cyc), 23);
        chk("lit_long_res", last_res, 32'h55AA55AA);
`endif

        // reset while waiting for the response; the response then arrives idle
        run_txn(1, 0, 32'h500, 32'h0, 4'b1111, 0, 3, 1, 32'h99999999, 0, 2);
        repeat (6) @(posedge clk);
        run_txn(1, 0, 32'h504, 32'h0, 4'b1111, 0, 0, 1, 32'h0BADF00D, 0, 0);
        chk("lit_post_rst_res", last_res, 32'h0BADF00D);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
